// File: rtl/pong_game_ctrl_pkg.sv
// Shared definitions for the pong game-flow controller: state encodings, default game
// parameters, winner codes and a saturating score increment.
package pong_game_ctrl_pkg;

  typedef enum logic [2:0] {
    StMenu     = 3'd0,
    StSet      = 3'd1,
    StServe    = 3'd2,
    StPlay     = 3'd3,
    StPoint    = 3'd4,
    StGameOver = 3'd5
  } pong_state_e;

  localparam logic [4:0] WinScoreDefault    = 5'd11;
  localparam logic [7:0] PointFramesDefault = 8'd60;
  localparam logic [4:0] ScoreMax           = 5'd31;

  localparam logic [1:0] WinNone = 2'b00;
  localparam logic [1:0] WinP1   = 2'b01;
  localparam logic [1:0] WinP2   = 2'b10;

  function automatic logic [4:0] sat_inc(input logic [4:0] s);
    return (s == ScoreMax) ? s : s + 5'd1;
  endfunction

endpackage

// File: rtl/pong_edge_det.sv
// Rising-edge detector; the history bit only advances when en is high, so the edge is
// measured against the level seen at the previous enabled cycle.
module pong_edge_det (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_q <= 1'b0;
    end else if (en) begin
      d_q <= d;
    end
  end

  assign rise = en & d & ~d_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-flow controller and score keeper.
// Optional build macro PONG_WIN_BY_TWO_EN: winning requires a two-point lead.
module pong_game_ctrl
  import pong_game_ctrl_pkg::*;
#(
  parameter logic [4:0] WIN_SCORE    = WinScoreDefault,
  parameter logic [7:0] POINT_FRAMES = PointFramesDefault
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       launch,
  input  logic       mode_btn,
  input  logic       left_hit,
  input  logic       right_hit,
  output logic [2:0] game_state,
  output logic [4:0] score_p1,
  output logic [4:0] score_p2,
  output logic       serve_side,
  output logic       mode_score,
  output logic [1:0] winner
);

  pong_state_e state_q, state_d;
  logic [4:0]  p1_q, p1_d, p2_q, p2_d;
  logic        serve_q, serve_d, mode_q, mode_d;
  logic [1:0]  winner_q, winner_d, win_code;
  logic [7:0]  cnt_q, cnt_d, cnt_inc;
  logic        launch_press, mode_press;

  pong_edge_det u_launch_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (1'b1),
    .d       (launch),
    .rise    (launch_press)
  );

  pong_edge_det u_mode_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (frame_tick),
    .d       (mode_btn),
    .rise    (mode_press)
  );

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    win_code = WinNone;
    if (mode_q) begin
`ifdef PONG_WIN_BY_TWO_EN
      // Saturated scores can no longer grow a lead, so the higher one takes it outright.
      if (p1_q == ScoreMax || p2_q == ScoreMax) begin
        if (p1_q > p2_q) win_code = WinP1;
        else if (p2_q > p1_q) win_code = WinP2;
      end else if (p1_q >= WIN_SCORE && {1'b0, p1_q} >= {1'b0, p2_q} + 6'd2) begin
        win_code = WinP1;
      end else if (p2_q >= WIN_SCORE && {1'b0, p2_q} >= {1'b0, p1_q} + 6'd2) begin
        win_code = WinP2;
      end
`else
      if (p1_q >= WIN_SCORE) win_code = WinP1;
      else if (p2_q >= WIN_SCORE) win_code = WinP2;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    serve_d  = serve_q;
    mode_d   = mode_q;
    winner_d = winner_q;
    cnt_d    = cnt_q;
    case (state_q)
      StMenu: begin
        if (mode_press) mode_d = ~mode_q;
        if (launch_press) begin
          p1_d     = '0;
          p2_d     = '0;
          winner_d = WinNone;
          serve_d  = 1'b0;
          state_d  = StServe;
        end
      end
      StServe: begin
        if (launch_press) state_d = StPlay;
      end
      StPlay: begin
        if (left_hit || right_hit) begin
          state_d = StPoint;
          cnt_d   = '0;
          if (right_hit && !left_hit) begin
            p1_d    = sat_inc(p1_q);
            serve_d = 1'b1;
          end else if (left_hit && !right_hit) begin
            p2_d    = sat_inc(p2_q);
            serve_d = 1'b0;
          end
        end
      end
      StPoint: begin
        if (frame_tick) begin
          cnt_d = cnt_inc;
          if (cnt_inc == POINT_FRAMES) begin
            if (win_code != WinNone) begin
              winner_d = win_code;
              state_d  = StGameOver;
            end else begin
              state_d = StServe;
            end
          end
        end
      end
      StGameOver: begin
        if (launch_press) begin
          p1_d     = '0;
          p2_d     = '0;
          winner_d = WinNone;
          state_d  = StMenu;
        end
      end
      default: state_d = StMenu;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StMenu;
      p1_q     <= '0;
      p2_q     <= '0;
      serve_q  <= 1'b0;
      mode_q   <= 1'b1;
      winner_q <= WinNone;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      serve_q  <= serve_d;
      mode_q   <= mode_d;
      winner_q <= winner_d;
      cnt_q    <= cnt_d;
    end
  end

  assign game_state = state_q;
  assign score_p1   = p1_q;
  assign score_p2   = p2_q;
  assign serve_side = serve_q;
  assign mode_score = mode_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: vector table, hand-written game sequences and
// randomized play against a behavioural game model.
module tb_pong_game_ctrl;

  localparam int W  = 3;
  localparam int PF = 60;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_tick = 1'b0, launch = 1'b0, mode_btn = 1'b0;
  logic       left_hit = 1'b0, right_hit = 1'b0;
  logic [2:0] game_state;
  logic [4:0] score_p1, score_p2;
  logic       serve_side, mode_score;
  logic [1:0] winner;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model of the game
  int m_state, m_p1, m_p2, m_serve, m_mode, m_winner, m_frames;
  bit m_launch_prev, m_mode_prev;

  pong_game_ctrl #(
    .WIN_SCORE    (5'd3),
    .POINT_FRAMES (8'd60)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_tick (frame_tick),
    .launch     (launch),
    .mode_btn   (mode_btn),
    .left_hit   (left_hit),
    .right_hit  (right_hit),
    .game_state (game_state),
    .score_p1   (score_p1),
    .score_p2   (score_p2),
    .serve_side (serve_side),
    .mode_score (mode_score),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_state = 0; m_p1 = 0; m_p2 = 0; m_serve = 0; m_mode = 1; m_winner = 0; m_frames = 0;
    m_launch_prev = 0; m_mode_prev = 0;
  endfunction

  function automatic int model_winner();
    if (m_mode == 0) return 0;
`ifdef PONG_WIN_BY_TWO_EN
    if (m_p1 == 31 && m_p2 == 31) return 0;
    if (m_p1 == 31 || m_p2 == 31) return (m_p1 > m_p2) ? 1 : 2;
    if (m_p1 >= W && m_p1 - m_p2 >= 2) return 1;
    if (m_p2 >= W && m_p2 - m_p1 >= 2) return 2;
    return 0;
`else
    if (m_p1 >= W) return 1;
    if (m_p2 >= W) return 2;
    return 0;
`endif
  endfunction

  function automatic void model_step(bit l, bit mb, bit lh, bit rh, bit ft);
    bit lp, mp;
    int w;
    lp = l && !m_launch_prev;
    mp = ft && mb && !m_mode_prev;
    m_launch_prev = l;
    if (ft) m_mode_prev = mb;
    case (m_state)
      0: begin
        if (mp) m_mode = 1 - m_mode;
        if (lp) begin
          m_p1 = 0; m_p2 = 0; m_winner = 0; m_serve = 0; m_state = 2;
        end
      end
      2: if (lp) m_state = 3;
      3: if (lh || rh) begin
        if (rh && !lh) begin m_p1 = (m_p1 < 31) ? m_p1 + 1 : 31; m_serve = 1; end
        if (lh && !rh) begin m_p2 = (m_p2 < 31) ? m_p2 + 1 : 31; m_serve = 0; end
        m_frames = 0;
        m_state = 4;
      end
      4: if (ft) begin
        m_frames++;
        if (m_frames == PF) begin
          w = model_winner();
          if (w != 0) begin m_winner = w; m_state = 5; end
          else m_state = 2;
        end
      end
      5: if (lp) begin
        m_p1 = 0; m_p2 = 0; m_winner = 0; m_state = 0;
      end
      default: m_state = 0;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("state", int'(game_state), m_state);
    check("score_p1", int'(score_p1), m_p1);
    check("score_p2", int'(score_p2), m_p2);
    check("serve_side", int'(serve_side), m_serve);
    check("mode_score", int'(mode_score), m_mode);
    check("winner", int'(winner), m_winner);
  endtask

  task automatic step(input bit l, input bit mb, input bit lh, input bit rh, input bit ft);
    launch = l; mode_btn = mb; left_hit = lh; right_hit = rh; frame_tick = ft;
    @(posedge clk);
    model_step(l, mb, lh, rh, ft);
    #1;
    check_model();
  endtask

  task automatic press_launch();
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1);
  endtask

  typedef struct {
    bit l, mb, lh, rh, ft;
    int st, p1, p2, sv;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // launch edge, held launch, hit in SERVE, launch to PLAY, let, hits in POINT
    vecs.push_back('{1, 0, 0, 0, 0, 2, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 0, 0, 2, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 1, 1, 2, 0, 0, 0});
    vecs.push_back('{0, 0, 1, 0, 0, 2, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 0, 0, 3, 0, 0, 0});
    vecs.push_back('{1, 0, 1, 1, 0, 4, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 1, 0, 4, 0, 0, 0});
    vecs.push_back('{1, 0, 1, 0, 1, 4, 0, 0, 0});

    model_reset();
    #12;
    check_model();
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].l, vecs[i].mb, vecs[i].lh, vecs[i].rh, vecs[i].ft);
      check($sformatf("vec%0d.state", i), int'(game_state), vecs[i].st);
      check($sformatf("vec%0d.p1", i), int'(score_p1), vecs[i].p1);
      check($sformatf("vec%0d.p2", i), int'(score_p2), vecs[i].p2);
      check($sformatf("vec%0d.serve", i), int'(serve_side), vecs[i].sv);
    end

    // One tick was already taken in POINT by the last vector
    ticks(PF - 2);
    check("point_hold", int'(game_state), 4);
    ticks(1);
    check("point_exit", int'(game_state), 2);

    press_launch();
    check("serve_to_play", int'(game_state), 3);
    step(0, 0, 0, 1, 0);
    check("p1_point_score", int'(score_p1), 1);
    check("p1_point_serve", int'(serve_side), 1);
    ticks(PF - 1);
    check("point_not_early", int'(game_state), 4);
    ticks(1);
    check("point_to_serve", int'(game_state), 2);

    for (int p = 0; p < 2; p++) begin
      press_launch();
      step(0, 0, 0, 1, 0);
      ticks(PF);
    end
    check("win_state", int'(game_state), 5);
    check("win_code", int'(winner), 1);
    check("win_score", int'(score_p1), 3);
    press_launch();
    check("over_to_menu", int'(game_state), 0);
    check("over_clear", int'(score_p1), 0);

    step(0, 1, 0, 0, 1);
    check("mode_toggle", int'(mode_score), 0);
    step(0, 1, 0, 0, 1);
    check("mode_no_retrigger", int'(mode_score), 0);
    step(0, 0, 0, 0, 1);
    press_launch();
    for (int p = 0; p < 35; p++) begin
      press_launch();
      step(0, 0, 0, 1, 0);
      ticks(PF);
      check("endless_serve", int'(game_state), 2);
    end
    check("endless_sat", int'(score_p1), 31);

    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(3) == 0), ($urandom_range(3) == 0), ($urandom_range(7) == 0),
           ($urandom_range(7) == 0), ($urandom_range(1) == 0));
    end

    // Asynchronous reset in the middle of a point
    step(0, 0, 0, 0, 0);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    model_reset();
    press_launch();
    press_launch();
    step(0, 0, 1, 0, 0);
    check("pre_reset_point", int'(game_state), 4);
    ticks(5);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_model();
    #4;
    reset_n = 1'b1;
    step(0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
